// File: rtl/operand_loader.sv
// Operand frame loader: gathers header + four operand bytes, runs the datapath, returns its result.
// Optional RUN watchdog enabled by defining OPLOAD_TIMEOUT_EN.
module operand_loader #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       start,
  output logic       mode,
  output logic [7:0] A,
  output logic [7:0] B,
  output logic [7:0] C,
  output logic [7:0] D,
  input  logic [7:0] result,
  input  logic       done,
  output logic       out_valid,
  output logic [7:0] out_data,
  input  logic       out_ready,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_EMIT = 2'd3
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [1:0] idx;
  logic       run_first;
  logic       accept;
  logic       capture;

`ifdef OPLOAD_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CNT_W-1:0] run_cnt;
  logic             tmo_fire;
`endif

  // Next-state logic; done is masked in the first RUN cycle to reject a stale pulse.
  always_comb begin
    state_nxt = state;
    accept    = in_valid & in_ready;
    capture   = 1'b0;
`ifdef OPLOAD_TIMEOUT_EN
    tmo_fire  = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        if (accept) state_nxt = S_LOAD;
      end
      S_LOAD: begin
        if (accept && (idx == 2'd3)) state_nxt = S_RUN;
      end
      S_RUN: begin
        if (!run_first && done) begin
          capture   = 1'b1;
          state_nxt = S_EMIT;
        end
`ifdef OPLOAD_TIMEOUT_EN
        else if (run_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          tmo_fire  = 1'b1;
          state_nxt = S_IDLE;
        end
`endif
      end
      S_EMIT: begin
        if (out_valid && out_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register and registered state decodes.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      run_first <= 1'b0;
      in_ready  <= 1'b1;
      start     <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      run_first <= (state != S_RUN) && (state_nxt == S_RUN);
      in_ready  <= (state_nxt == S_IDLE) || (state_nxt == S_LOAD);
      start     <= (state_nxt == S_RUN);
      out_valid <= (state_nxt == S_EMIT);
      busy      <= (state_nxt != S_IDLE);
    end
  end

  // Frame capture: header sets mode, then operands in order A..D.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx  <= 2'd0;
      mode <= 1'b0;
      A    <= 8'h00;
      B    <= 8'h00;
      C    <= 8'h00;
      D    <= 8'h00;
    end else if (accept) begin
      if (state == S_IDLE) begin
        mode <= in_data[0];
        idx  <= 2'd0;
      end else if (state == S_LOAD) begin
        case (idx)
          2'd0:    A <= in_data;
          2'd1:    B <= in_data;
          2'd2:    C <= in_data;
          default: D <= in_data;
        endcase
        idx <= idx + 2'd1;
      end
    end
  end

  // Result register holds until the next successful capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_data <= 8'h00;
    end else if (capture) begin
      out_data <= result;
    end
  end

`ifdef OPLOAD_TIMEOUT_EN
  // RUN watchdog: counts RUN cycles, restarts on each RUN entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      run_cnt <= '0;
      timeout <= 1'b0;
    end else begin
      timeout <= tmo_fire;
      if ((state != S_RUN) && (state_nxt == S_RUN)) begin
        run_cnt <= '0;
      end else if (state == S_RUN) begin
        run_cnt <= run_cnt + CNT_W'(1);
      end
    end
  end
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_operand_loader.sv
// Directed self-checking bench for operand_loader with a datapath stub (done 3 cycles after start, result 5A).
module tb_operand_loader;

  localparam int unsigned TMO = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       start;
  logic       mode;
  logic [7:0] A, B, C, D;
  logic [7:0] result;
  logic       done;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;
  logic       busy;
  logic       timeout;

  logic       stub_en;
  logic [2:0] stub_cnt;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  operand_loader #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .start(start), .mode(mode), .A(A), .B(B), .C(C), .D(D),
    .result(result), .done(done),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .busy(busy), .timeout(timeout)
  );

  // Datapath stub: done rises in the 4th cycle of start.
  always @(posedge clk) begin
    if (!start) stub_cnt <= 3'd0;
    else if (stub_cnt != 3'd3) stub_cnt <= stub_cnt + 3'd1;
  end
  assign done   = stub_en && start && (stub_cnt == 3'd3);
  assign result = 8'h5A;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    step();
    in_valid = 1'b0;
    in_data  = 8'hEE;
  endtask

  task automatic send_frame(input logic [7:0] h, input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] c, input logic [7:0] d);
    send(h); send(a); send(b); send(c); send(d);
  endtask

  task automatic wait_out(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b1; stub_en = 1'b1;
    step(); step();
    n_total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b exp=1", in_ready); else n_pass++;
    n_total++; if (start !== 1'b0) $display("FAIL reset_start got=%b exp=0", start); else n_pass++;
    n_total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", out_valid); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else n_pass++;
    n_total++; if (timeout !== 1'b0) $display("FAIL reset_timeout got=%b exp=0", timeout); else n_pass++;
    n_total++; if (mode !== 1'b0) $display("FAIL reset_mode got=%b exp=0", mode); else n_pass++;
    n_total++; if ({A, B, C, D} !== 32'h0) $display("FAIL reset_operands got=%h exp=00000000", {A, B, C, D}); else n_pass++;
    n_total++; if (out_data !== 8'h00) $display("FAIL reset_out_data got=%h exp=00", out_data); else n_pass++;
    reset = 1'b0;
  endtask

  task automatic test_basic_frame();
    int n;
    out_ready = 1'b1;
    send_frame(8'h01, 8'h01, 8'h02, 8'hFF, 8'hFE);
    n_total++; if (mode !== 1'b1) $display("FAIL basic_mode got=%b exp=1", mode); else n_pass++;
    n_total++; if ({A, B, C, D} !== 32'h0102FFFE) $display("FAIL basic_operands got=%h exp=0102fffe", {A, B, C, D}); else n_pass++;
    n_total++; if (in_ready !== 1'b0) $display("FAIL basic_in_ready_run got=%b exp=0", in_ready); else n_pass++;
    n_total++; if (busy !== 1'b1) $display("FAIL basic_busy_run got=%b exp=1", busy); else n_pass++;
    n = 0;
    while (start && n < 20) begin n++; step(); end
    n_total++; if (n !== 4) $display("FAIL basic_start_cycles got=%0d exp=4", n); else n_pass++;
    n_total++; if (out_valid !== 1'b1) $display("FAIL basic_out_valid got=%b exp=1", out_valid); else n_pass++;
    n_total++; if (out_data !== 8'h5A) $display("FAIL basic_out_data got=%h exp=5a", out_data); else n_pass++;
    step();
    n_total++; if (out_valid !== 1'b0) $display("FAIL basic_out_valid_drop got=%b exp=0", out_valid); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL basic_busy_drop got=%b exp=0", busy); else n_pass++;
    n_total++; if (in_ready !== 1'b1) $display("FAIL basic_in_ready_idle got=%b exp=1", in_ready); else n_pass++;
    n_total++; if ({A, B, C, D} !== 32'h0102FFFE) $display("FAIL basic_operands_hold got=%h exp=0102fffe", {A, B, C, D}); else n_pass++;
  endtask

  task automatic test_gaps();
    bit ok;
    send(8'hFE);
    in_data = 8'h77; step(); step();
    n_total++; if (A !== 8'h01) $display("FAIL gaps_a_untouched got=%h exp=01", A); else n_pass++;
    n_total++; if (busy !== 1'b1) $display("FAIL gaps_busy got=%b exp=1", busy); else n_pass++;
    send(8'h11); in_data = 8'h77; step();
    send(8'h22); in_data = 8'h77; step(); step();
    send(8'h33); in_data = 8'h77; step();
    send(8'h44);
    n_total++; if (mode !== 1'b0) $display("FAIL gaps_mode got=%b exp=0", mode); else n_pass++;
    n_total++; if ({A, B, C, D} !== 32'h11223344) $display("FAIL gaps_operands got=%h exp=11223344", {A, B, C, D}); else n_pass++;
    wait_out(ok);
    n_total++; if (ok !== 1'b1) $display("FAIL gaps_wait_out got=timeout exp=out_valid"); else n_pass++;
    n_total++; if (out_data !== 8'h5A) $display("FAIL gaps_out_data got=%h exp=5a", out_data); else n_pass++;
    step();
  endtask

  task automatic test_emit_hold();
    bit ok;
    out_ready = 1'b0;
    send_frame(8'h00, 8'h10, 8'h20, 8'h30, 8'h40);
    wait_out(ok);
    n_total++; if (ok !== 1'b1) $display("FAIL hold_wait_out got=timeout exp=out_valid"); else n_pass++;
    in_valid = 1'b1; in_data = 8'h03;
    for (int i = 0; i < 5; i++) begin
      n_total++; if (out_valid !== 1'b1) $display("FAIL hold_out_valid[%0d] got=%b exp=1", i, out_valid); else n_pass++;
      n_total++; if (out_data !== 8'h5A) $display("FAIL hold_out_data[%0d] got=%h exp=5a", i, out_data); else n_pass++;
      n_total++; if (in_ready !== 1'b0) $display("FAIL hold_in_ready[%0d] got=%b exp=0", i, in_ready); else n_pass++;
      n_total++; if (mode !== 1'b0) $display("FAIL hold_mode[%0d] got=%b exp=0", i, mode); else n_pass++;
      step();
    end
    out_ready = 1'b1;
    step();
    n_total++; if (out_valid !== 1'b0) $display("FAIL hold_released got=%b exp=0", out_valid); else n_pass++;
    n_total++; if (in_ready !== 1'b1) $display("FAIL hold_idle_in_ready got=%b exp=1", in_ready); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL hold_idle_busy got=%b exp=0", busy); else n_pass++;
    n_total++; if (mode !== 1'b0) $display("FAIL hold_byte_not_consumed got=%b exp=0", mode); else n_pass++;
    step();
    in_valid = 1'b0;
    n_total++; if (mode !== 1'b1) $display("FAIL hold_header_taken got=%b exp=1", mode); else n_pass++;
    n_total++; if (busy !== 1'b1) $display("FAIL hold_load_busy got=%b exp=1", busy); else n_pass++;
    send(8'h04); send(8'h03); send(8'h02); send(8'h01);
    n_total++; if ({A, B, C, D} !== 32'h04030201) $display("FAIL hold_next_operands got=%h exp=04030201", {A, B, C, D}); else n_pass++;
    wait_out(ok);
    n_total++; if (ok !== 1'b1) $display("FAIL hold_next_wait_out got=timeout exp=out_valid"); else n_pass++;
    step();
  endtask

  task automatic test_reset_load();
    bit ok;
    send(8'h01); send(8'hAA); send(8'hBB);
    n_total++; if ({A, B} !== 16'hAABB) $display("FAIL rload_partial got=%h exp=aabb", {A, B}); else n_pass++;
    reset = 1'b1; step(); reset = 1'b0;
    n_total++; if ({A, B, C, D} !== 32'h0) $display("FAIL rload_operands got=%h exp=00000000", {A, B, C, D}); else n_pass++;
    n_total++; if (mode !== 1'b0) $display("FAIL rload_mode got=%b exp=0", mode); else n_pass++;
    n_total++; if (in_ready !== 1'b1 || busy !== 1'b0 || start !== 1'b0)
      $display("FAIL rload_ctrl got=in_ready%b busy%b start%b exp=in_ready1 busy0 start0", in_ready, busy, start); else n_pass++;
    n_total++; if (out_data !== 8'h00) $display("FAIL rload_out_data got=%h exp=00", out_data); else n_pass++;
    send_frame(8'h01, 8'hC1, 8'hC2, 8'hC3, 8'hC4);
    n_total++; if ({mode, A, B, C, D} !== 33'h1C1C2C3C4) $display("FAIL rload_refill got=%h exp=1c1c2c3c4", {mode, A, B, C, D}); else n_pass++;
    wait_out(ok);
    n_total++; if (ok !== 1'b1 || out_data !== 8'h5A) $display("FAIL rload_result got=ok%b data%h exp=ok1 data5a", ok, out_data); else n_pass++;
    step();
  endtask

  task automatic test_reset_run();
    bit ok;
    send_frame(8'h00, 8'hD1, 8'hD2, 8'hD3, 8'hD4);
    step();
    n_total++; if (start !== 1'b1) $display("FAIL rrun_start got=%b exp=1", start); else n_pass++;
    reset = 1'b1; step(); reset = 1'b0;
    n_total++; if (start !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL rrun_ctrl got=start%b out_valid%b busy%b in_ready%b exp=start0 out_valid0 busy0 in_ready1",
               start, out_valid, busy, in_ready); else n_pass++;
    n_total++; if ({A, B, C, D} !== 32'h0 || out_data !== 8'h00)
      $display("FAIL rrun_data got=%h/%h exp=00000000/00", {A, B, C, D}, out_data); else n_pass++;
    send_frame(8'h01, 8'hE1, 8'hE2, 8'hE3, 8'hE4);
    wait_out(ok);
    n_total++; if (ok !== 1'b1 || out_data !== 8'h5A) $display("FAIL rrun_result got=ok%b data%h exp=ok1 data5a", ok, out_data); else n_pass++;
    step();
  endtask

  task automatic test_timeout();
    int  n;
    bit  saw_tmo;
    stub_en = 1'b0;
    send_frame(8'h01, 8'h0A, 8'h0B, 8'h0C, 8'h0D);
    n = 0; saw_tmo = 1'b0;
`ifdef OPLOAD_TIMEOUT_EN
    while (start && n < 150) begin n++; step(); end
    n_total++; if (n !== TMO) $display("FAIL tmo_run_cycles got=%0d exp=%0d", n, TMO); else n_pass++;
    n_total++; if (timeout !== 1'b1) $display("FAIL tmo_pulse got=%b exp=1", timeout); else n_pass++;
    n_total++; if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL tmo_idle got=busy%b out_valid%b in_ready%b exp=busy0 out_valid0 in_ready1", busy, out_valid, in_ready); else n_pass++;
    n_total++; if (out_data !== 8'h5A) $display("FAIL tmo_out_data got=%h exp=5a", out_data); else n_pass++;
    step();
    n_total++; if (timeout !== 1'b0) $display("FAIL tmo_single got=%b exp=0", timeout); else n_pass++;
`else
    for (int i = 0; i < 120; i++) begin
      if (start) n++;
      if (timeout) saw_tmo = 1'b1;
      step();
    end
    n_total++; if (n !== 120) $display("FAIL notmo_start_cycles got=%0d exp=120", n); else n_pass++;
    n_total++; if (saw_tmo !== 1'b0) $display("FAIL notmo_timeout got=%b exp=0", saw_tmo); else n_pass++;
    n_total++; if (out_valid !== 1'b0) $display("FAIL notmo_out_valid got=%b exp=0", out_valid); else n_pass++;
    reset = 1'b1; step(); reset = 1'b0;
`endif
    stub_en = 1'b1;
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_gaps();
    test_emit_hold();
    test_reset_load();
    test_reset_run();
    test_timeout();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=stuck exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
